id_fp_regfile_mp: RTL and testbench

//   Parametrised multi-port FP register file with a pending-write scoreboard, used in the ID stage.

---
 rtl/fp_rf_pkg.sv | 11 +
 rtl/fp_rf_scoreboard.sv | 66 ++++++
 rtl/id_fp_regfile_mp.sv | 90 +++++++++
 tb/tb_id_fp_regfile_mp.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_rf_pkg.sv
// Shared defaults and types for the multi-port FP register file.
package fp_rf_pkg;

    localparam int FP_DATA_W   = 32;
    localparam int FP_NUM_REGS = 32;
    localparam int FP_AW       = $clog2(FP_NUM_REGS);

    typedef logic [FP_DATA_W-1:0] fp_reg_t;
    typedef logic [FP_AW-1:0]     fp_addr_t;

endpackage

// File: rtl/fp_rf_scoreboard.sv
// Pending-write scoreboard: per-register busy bits, registered busy count and WAW issue stall.
module fp_rf_scoreboard #(
    parameter  int NUM_REGS = 32,
    parameter  int NUM_WR   = 2,
    localparam int AW       = $clog2(NUM_REGS),
    localparam int CW       = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR-1:0]    wr_clr,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_rd,
    output logic                 iss_stall,
    output logic [NUM_REGS-1:0]  busy,
    output logic [CW-1:0]        busy_cnt
);

    logic [NUM_REGS-1:0] busy_next;
    logic [CW-1:0]       cnt_next;
    logic [NUM_WR-1:0]   clr_hit;
    logic                iss_ok;

    // Stall looks only at registered busy state, so a same-cycle retire never lifts it.
    assign iss_stall = iss_en & busy[iss_rd];
    assign iss_ok    = iss_en & ~busy[iss_rd];

    always_comb begin
        busy_next = busy;
        clr_hit   = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k] && wr_clr[k]) begin
                clr_hit[k] = busy[wr_addr[k*AW +: AW]];
                busy_next[wr_addr[k*AW +: AW]] = 1'b0;
            end
        end
        // Two ports retiring the same register must only decrement once.
        for (int k = 1; k < NUM_WR; k++) begin
            for (int j = 0; j < k; j++) begin
                if (wr_en[j] && wr_clr[j] && (wr_addr[j*AW +: AW] == wr_addr[k*AW +: AW])) begin
                    clr_hit[k] = 1'b0;
                end
            end
        end
        // An accepted issue targets a non-busy register, so applying it last makes set win.
        if (iss_ok) begin
            busy_next[iss_rd] = 1'b1;
        end
        cnt_next = busy_cnt + CW'(iss_ok);
        for (int k = 0; k < NUM_WR; k++) begin
            cnt_next = cnt_next - CW'(clr_hit[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_next;
            busy_cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/id_fp_regfile_mp.sv
// Multi-port FP register file for ID with pending-write scoreboard.
// Define FP_RF_BYPASS_EN to forward same-cycle write data and clears to the read ports.
module id_fp_regfile_mp
    import fp_rf_pkg::*;
#(
    parameter  int DATA_W   = FP_DATA_W,
    parameter  int NUM_REGS = FP_NUM_REGS,
    parameter  int NUM_RD   = 3,
    parameter  int NUM_WR   = 2,
    localparam int AW       = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*AW-1:0]     wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic [NUM_WR-1:0]        wr_clr_i,
    input  logic                     iss_en_i,
    input  logic [AW-1:0]            iss_rd_i,
    output logic                     iss_stall_o,
    output logic [AW:0]              busy_cnt_o
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [AW-1:0]       ra;
`ifdef FP_RF_BYPASS_EN
    logic [AW-1:0]       wa;
`endif

    fp_rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en_i),
        .wr_clr    (wr_clr_i),
        .wr_addr   (wr_addr_i),
        .iss_en    (iss_en_i),
        .iss_rd    (iss_rd_i),
        .iss_stall (iss_stall_o),
        .busy      (busy),
        .busy_cnt  (busy_cnt_o)
    );

    // Later ports are assigned last, so the late FDIV/FSQRT writeback wins an address collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en_i[k]) begin
                    regs[wr_addr_i[k*AW +: AW]] <= wr_data_i[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        ra        = '0;
`ifdef FP_RF_BYPASS_EN
        wa        = '0;
`endif
        for (int r = 0; r < NUM_RD; r++) begin
            ra = rd_addr_i[r*AW +: AW];
            rd_data_o[r*DATA_W +: DATA_W] = regs[ra];
            rd_busy_o[r] = busy[ra];
`ifdef FP_RF_BYPASS_EN
            for (int k = 0; k < NUM_WR; k++) begin
                wa = wr_addr_i[k*AW +: AW];
                if (wr_en_i[k] && (wa == ra)) begin
                    rd_data_o[r*DATA_W +: DATA_W] = wr_data_i[k*DATA_W +: DATA_W];
                    if (wr_clr_i[k]) begin
                        rd_busy_o[r] = 1'b0;
                    end
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_id_fp_regfile_mp.sv
// Directed self-checking bench for id_fp_regfile_mp (both FP_RF_BYPASS_EN builds).
module tb_id_fp_regfile_mp;
    import fp_rf_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [14:0] rd_addr;
    logic [95:0] rd_data;
    logic [2:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic [1:0]  wr_clr;
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic        iss_stall;
    logic [5:0]  busy_cnt;

    int checks = 0;
    int errors = 0;

    id_fp_regfile_mp dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .rd_busy_o   (rd_busy),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .wr_clr_i    (wr_clr),
        .iss_en_i    (iss_en),
        .iss_rd_i    (iss_rd),
        .iss_stall_o (iss_stall),
        .busy_cnt_o  (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: bench did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en   = '0;
        wr_clr  = '0;
        wr_addr = '0;
        wr_data = '0;
        iss_en  = 1'b0;
        iss_rd  = '0;
    endtask

    initial begin
        fp_reg_t  exp_val;
        fp_addr_t a;

        rst_n   = 1'b0;
        rd_addr = '0;
        idle_inputs();
        #2;

        // Reset state: every register on every port reads zero and nothing is busy.
        for (int i = 0; i < 32; i++) begin
            rd_addr = {5'((i + 22) % 32), 5'((i + 11) % 32), 5'(i)};
            #1;
            check("rst_rd0", rd_data[31:0], 32'h0);
            check("rst_rd1", rd_data[63:32], 32'h0);
            check("rst_rd2", rd_data[95:64], 32'h0);
            check("rst_busy", {29'h0, rd_busy}, 32'h0);
        end
        check("rst_cnt", {26'h0, busy_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Both write ports hit f5: the late port wins.
        wr_en   = 2'b11;
        wr_addr = {5'd5, 5'd5};
        wr_data = {32'h40000000, 32'h3F800000};
        tick();
        idle_inputs();
        rd_addr = {5'd0, 5'd0, 5'd5};
        #1;
        check("wr_collide", rd_data[31:0], 32'h40000000);

        // Issue f7, then a WAW re-issue stalls and changes nothing.
        iss_en = 1'b1;
        iss_rd = 5'd7;
        #1;
        check("iss7_nostall", {31'h0, iss_stall}, 32'h0);
        tick();
        rd_addr = {5'd0, 5'd0, 5'd7};
        #1;
        check("iss7_stall", {31'h0, iss_stall}, 32'h1);
        check("iss7_cnt", {26'h0, busy_cnt}, 32'd1);
        check("iss7_rdbusy", {31'h0, rd_busy[0]}, 32'h1);
        tick();
        check("iss7_cnt_hold", {26'h0, busy_cnt}, 32'd1);

        // Late writeback retires f7.
        idle_inputs();
        wr_en   = 2'b10;
        wr_clr  = 2'b10;
        wr_addr = {5'd7, 5'd0};
        wr_data = {32'h12345678, 32'h0};
        #1;
`ifdef FP_RF_BYPASS_EN
        check("clr7_samecyc_busy", {31'h0, rd_busy[0]}, 32'h0);
`else
        check("clr7_samecyc_busy", {31'h0, rd_busy[0]}, 32'h1);
`endif
        tick();
        idle_inputs();
        #1;
        check("clr7_busy", {31'h0, rd_busy[0]}, 32'h0);
        check("clr7_cnt", {26'h0, busy_cnt}, 32'd0);
        check("clr7_data", rd_data[31:0], 32'h12345678);

        // Clear without enable is ignored.
        iss_en = 1'b1;
        iss_rd = 5'd10;
        tick();
        idle_inputs();
        wr_clr  = 2'b01;
        wr_addr = {5'd0, 5'd10};
        tick();
        idle_inputs();
        rd_addr = {5'd0, 5'd10, 5'd0};
        #1;
        check("clr_noen_cnt", {26'h0, busy_cnt}, 32'd1);
        check("clr_noen_busy", {31'h0, rd_busy[1]}, 32'h1);

        // Re-issue of f10 stalls even while both ports retire f10; count drops by one only.
        iss_en  = 1'b1;
        iss_rd  = 5'd10;
        wr_en   = 2'b11;
        wr_clr  = 2'b11;
        wr_addr = {5'd10, 5'd10};
        wr_data = {32'hAAAA0001, 32'hBBBB0002};
        #1;
        check("clr10_stall", {31'h0, iss_stall}, 32'h1);
        tick();
        idle_inputs();
        #1;
        check("clr10_cnt", {26'h0, busy_cnt}, 32'd0);
        check("clr10_busy", {31'h0, rd_busy[1]}, 32'h0);
        check("clr10_data", rd_data[63:32], 32'hAAAA0001);

        // Issue f3 while f3 gets a no-op clear and f8 gets a real one: net count unchanged.
        iss_en = 1'b1;
        iss_rd = 5'd8;
        tick();
        check("iss8_cnt", {26'h0, busy_cnt}, 32'd1);
        iss_rd  = 5'd3;
        wr_en   = 2'b11;
        wr_clr  = 2'b11;
        wr_addr = {5'd3, 5'd8};
        wr_data = {32'h33333333, 32'h88888888};
        tick();
        idle_inputs();
        rd_addr = {5'd0, 5'd8, 5'd3};
        #1;
        check("setclr3_busy", {31'h0, rd_busy[0]}, 32'h1);
        check("setclr8_busy", {31'h0, rd_busy[1]}, 32'h0);
        check("setclr_cnt", {26'h0, busy_cnt}, 32'd1);
        wr_en   = 2'b10;
        wr_clr  = 2'b10;
        wr_addr = {5'd3, 5'd0};
        wr_data = {32'h3F3F3F3F, 32'h0};
        tick();
        idle_inputs();
        #1;
        check("clr3_cnt", {26'h0, busy_cnt}, 32'd0);

        // Read f9 in the same cycle it is written.
        wr_en   = 2'b01;
        wr_addr = {5'd0, 5'd9};
        wr_data = {32'h0, 32'h11111111};
        tick();
        wr_data = {32'h0, 32'hC0490FDB};
        rd_addr = {5'd0, 5'd9, 5'd0};
        #1;
`ifdef FP_RF_BYPASS_EN
        exp_val = 32'hC0490FDB;
`else
        exp_val = 32'h11111111;
`endif
        check("byp9_same", rd_data[63:32], exp_val);
        tick();
        idle_inputs();
        #1;
        check("byp9_next", rd_data[63:32], 32'hC0490FDB);

        // Scoreboard three registers, then reset asynchronously mid-cycle.
        for (int i = 0; i < 3; i++) begin
            a = (i == 0) ? 5'd1 : (i == 1) ? 5'd2 : 5'd4;
            iss_en = 1'b1;
            iss_rd = a;
            tick();
        end
        idle_inputs();
        rd_addr = {5'd4, 5'd2, 5'd1};
        #1;
        check("pre_rst_cnt", {26'h0, busy_cnt}, 32'd3);
        check("pre_rst_busy", {29'h0, rd_busy}, 32'h7);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_cnt", {26'h0, busy_cnt}, 32'd0);
        check("async_rst_busy", {29'h0, rd_busy}, 32'h0);
        rd_addr = {5'd7, 5'd9, 5'd5};
        #1;
        check("async_rst_f5", rd_data[31:0], 32'h0);
        check("async_rst_f7", rd_data[95:64], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Straggling writeback after reset writes data; its clear is a no-op.
        wr_en   = 2'b10;
        wr_clr  = 2'b10;
        wr_addr = {5'd2, 5'd0};
        wr_data = {32'hDEADBEEF, 32'h0};
        tick();
        idle_inputs();
        rd_addr = {5'd0, 5'd0, 5'd2};
        #1;
        check("late_wb_data", rd_data[31:0], 32'hDEADBEEF);
        check("late_wb_cnt", {26'h0, busy_cnt}, 32'd0);
        check("late_wb_busy", {31'h0, rd_busy[0]}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
